rms_arbiter: RTL and testbench
==============================

RMS_ARBITER -- requirements
Module: rms_arbiter

Interface
REQ-001 SHALL have parameter: NumReq, default NumRmsRequesters (config_pkg, 2), number of requesters sharing one RMS-norm unit.
REQ-002 SHALL have port: clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_ni  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: req_valid_i  input  NumReq  per-requester operand valid.
REQ-005 SHALL have port: req_ready_o  output  NumReq  per-requester operand accept (one-hot or zero).
REQ-006 SHALL have port: req_data_i  input  NumReq x vector_t  per-requester operand vectors.
REQ-007 SHALL have port: rsp_valid_o  output  NumReq  per-requester result valid (one-hot or zero).
REQ-008 SHALL have port: rsp_ready_i  input  NumReq  per-requester result accept.
REQ-009 SHALL have port: rsp_data_o  output  vector_t  shared result bus, meaningful where rsp_valid_o set.
REQ-010 SHALL have port: rms_in_ready_i  input  1  RMS unit ready for operand.
REQ-011 SHALL have port: rms_in_valid_o  output  1  operand valid to RMS unit.
REQ-012 SHALL have port: rms_a_o  output  vector_t  operand to RMS unit.
REQ-013 SHALL have port: rms_out_valid_i  input  1  RMS result strobe (single-cycle, no backpressure).
REQ-014 SHALL have port: rms_result_i  input  vector_t  RMS result.

Function
REQ-015 SHALL implement FSM IDLE, ISSUE, BUSY, RESPOND.
REQ-016 IDLE: if any req_valid_i set, select winner by round-robin starting at rr_ptr; assert req_ready_o[winner] that cycle only; latch req_data_i[winner] into operand register and winner into owner; -> ISSUE.
REQ-017 IDLE with no req_valid_i: all req_ready_o 0, stay IDLE.
REQ-018 ISSUE: rms_in_valid_o=1; when rms_in_ready_i=1 -> BUSY; else hold.
REQ-019 rms_a_o SHALL always equal operand register; register SHALL be stable from ISSUE until RMS result captured (RMS unit reads operand elementwise over many cycles).
REQ-020 BUSY: rms_in_valid_o=0; on rms_out_valid_i=1 capture rms_result_i into result register -> RESPOND.
REQ-021 rms_out_valid_i in IDLE, ISSUE or RESPOND SHALL be ignored (no state/register change).
REQ-022 RESPOND: rsp_valid_o[owner]=1, rsp_data_o=result register; on rsp_ready_i[owner]=1 set rr_ptr=(owner+1) mod NumReq, -> IDLE. rsp_ready_i of non-owners ignored.
REQ-023 No new operand SHALL be accepted before RESPOND completes (one transaction in flight); latency req accept to rsp_valid = 1 + RMS handshake wait + RMS compute + 1 cycle.
REQ-024 Round-robin: a requester holding req_valid_i continuously SHALL be granted within NumReq transactions.
REQ-025 Winner same cycle as IDLE exit; RESPOND->IDLE costs one cycle (no bypass).

Reset
REQ-026 On rst_ni=0 at clock edge: state=IDLE, rr_ptr=0, owner=0, operand and result registers=0.
REQ-027 Outputs in/after reset: req_ready_o=0 (until IDLE evaluates requests), rsp_valid_o=0, rms_in_valid_o=0, rms_a_o=0, rsp_data_o=0.
REQ-028 Reset mid-transaction SHALL drop it silently; no rsp_valid_o for it (RMS unit shares rst_ni).

Structure
REQ-029 NumRmsRequesters and req_idx_t (logic [$clog2(NumRmsRequesters)-1:0]) SHALL live in config_pkg; vector_t reused from config_pkg.
REQ-030 Round-robin selection SHALL be one combinational sub-module rr_pick (inputs valid vector, pointer; outputs one-hot grant, index, any).

Verification
REQ-031 Single: req_valid_i=01, data all elements 1.0, RMS model returns after 10 cycles -> rsp_valid_o=01 with model result, req_ready_o[0] pulsed exactly once.
REQ-032 Contention: req_valid_i=11 held, rr_ptr=0 -> grants order 0,1,0,1 over four transactions.
REQ-033 Stall: rms_in_ready_i=0 for 5 cycles in ISSUE -> rms_in_valid_o held 5+1 cycles, rms_a_o unchanged throughout.
REQ-034 Response backpressure: rsp_ready_i[1]=0 for 4 cycles -> rsp_valid_o=10 held, rsp_data_o stable, req_ready_o=00, new req_valid_i[0] not granted.
REQ-035 Spurious: rms_out_valid_i pulsed in IDLE and ISSUE -> no state change, no rsp_valid_o.
REQ-036 Reset in BUSY: rst_ni=0 one cycle -> state IDLE, rsp_valid_o never asserted, next request from requester 0 granted.

Source files
------------

// File: rtl/config_pkg.sv
// Shared configuration: requester count, requester index type and the RMS vector type.
package config_pkg;

  localparam int unsigned NumRmsRequesters = 2;
  localparam int unsigned VecLen           = 4;
  localparam int unsigned ElemW            = 16;

  typedef logic [VecLen-1:0][ElemW-1:0]              vector_t;
  typedef logic [$clog2(NumRmsRequesters)-1:0]       req_idx_t;

endpackage

// File: rtl/rms_arbiter_pkg.sv
// Local types and helpers for the RMS-norm unit arbiter.
package rms_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StRespond
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after the pointer.
module rr_pick #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = 1
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = IdxW'((32'(ptr_i) + off) % NumReq);
      if (!any_o && valid_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/rms_arbiter.sv
// Shares one RMS-norm unit among NumReq requesters, one transaction in flight,
// round-robin fairness, result returned to the requester that issued it.
module rms_arbiter
  import config_pkg::*;
  import rms_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = NumRmsRequesters
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_valid_i,
  output logic [NumReq-1:0]    req_ready_o,
  input  vector_t [NumReq-1:0] req_data_i,
  output logic [NumReq-1:0]    rsp_valid_o,
  input  logic [NumReq-1:0]    rsp_ready_i,
  output vector_t              rsp_data_o,
  input  logic                 rms_in_ready_i,
  output logic                 rms_in_valid_o,
  output vector_t              rms_a_o,
  input  logic                 rms_out_valid_i,
  input  vector_t              rms_result_i
);

  localparam int unsigned IdxW = idx_w(NumReq);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] owner_q, rr_ptr_q, ptr_next, pick_idx;
  vector_t         operand_q, result_q;
  logic [NumReq-1:0] grant;
  logic            pick_any;
  logic            owner_done;

  rr_pick #(
    .NumReq(NumReq),
    .IdxW  (IdxW)
  ) u_rr_pick (
    .valid_i(req_valid_i),
    .ptr_i  (rr_ptr_q),
    .grant_o(grant),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign owner_done = rsp_ready_i[owner_q];
  assign ptr_next   = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pick_any)        state_d = StIssue;
      StIssue:   if (rms_in_ready_i)  state_d = StBusy;
      StBusy:    if (rms_out_valid_i) state_d = StRespond;
      StRespond: if (owner_done)      state_d = StIdle;
      default:                        state_d = StIdle;
    endcase
  end

  // Operand is only written in IDLE, so it stays put while the unit streams it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      operand_q <= '0;
      result_q  <= '0;
    end else begin
      if (state_q == StIdle && pick_any) begin
        operand_q <= req_data_i[pick_idx];
        owner_q   <= pick_idx;
      end
      if (state_q == StBusy && rms_out_valid_i) begin
        result_q <= rms_result_i;
      end
      if (state_q == StRespond && owner_done) begin
        rr_ptr_q <= ptr_next;
      end
    end
  end

  always_comb begin
    req_ready_o    = '0;
    rsp_valid_o    = '0;
    rms_in_valid_o = 1'b0;
    if (state_q == StIdle && rst_ni) begin
      req_ready_o = grant;
    end
    if (state_q == StIssue) begin
      rms_in_valid_o = 1'b1;
    end
    if (state_q == StRespond) begin
      rsp_valid_o[owner_q] = 1'b1;
    end
  end

  assign rms_a_o    = operand_q;
  assign rsp_data_o = result_q;

endmodule

// File: tb/tb_rms_arbiter.sv
// Directed bench for rms_arbiter; the RMS unit is modelled inline as bitwise inversion.
module tb_rms_arbiter;
  import config_pkg::*;

  localparam vector_t D0 = {4{16'h0100}};
  localparam vector_t R0 = {4{16'hfeff}};
  localparam vector_t D1 = {4{16'h0200}};
  localparam vector_t R1 = {4{16'hfdff}};
  localparam vector_t Junk = {4{16'hdead}};

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [1:0]    req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  vector_t [1:0] req_data_i;
  vector_t       rsp_data_o, rms_a_o, rms_result_i;
  logic          rms_in_ready_i, rms_in_valid_o, rms_out_valid_i;

  int n_chk = 0;
  int n_pass = 0;
  int rdy0_cnt = 0;

  rms_arbiter #(
    .NumReq(2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_data_i     (req_data_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .rms_in_ready_i (rms_in_ready_i),
    .rms_in_valid_o (rms_in_valid_o),
    .rms_a_o        (rms_a_o),
    .rms_out_valid_i(rms_out_valid_i),
    .rms_result_i   (rms_result_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (req_ready_o[0]) rdy0_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One full transaction: optional spurious strobes, ISSUE stall, RMS latency, response stall.
  task automatic txn(input string tag, input logic [1:0] valid, input logic [1:0] exp_grant,
                     input int stall, input int lat, input int bp, input bit spur);
    vector_t opnd, res;
    opnd = exp_grant[1] ? D1 : D0;
    res  = exp_grant[1] ? R1 : R0;
    if (spur) begin
      @(negedge clk);
      req_valid_i = 2'b00; rms_out_valid_i = 1'b1; rms_result_i = Junk;
      #1;
      chk({tag, "/spur_idle_rdy"}, req_ready_o, 2'b00);
      chk({tag, "/spur_idle_in"}, rms_in_valid_o, 1'b0);
      chk({tag, "/spur_idle_rsp"}, rsp_valid_o, 2'b00);
    end
    @(negedge clk);
    req_valid_i = valid; req_data_i[0] = D0; req_data_i[1] = D1;
    rms_out_valid_i = 1'b0; rms_in_ready_i = 1'b0; rsp_ready_i = 2'b00;
    #1;
    chk({tag, "/grant"}, req_ready_o, exp_grant);
    chk({tag, "/idle_in"}, rms_in_valid_o, 1'b0);
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      rms_in_ready_i = (s == stall);
      rms_out_valid_i = spur && (s == 0);
      rms_result_i = Junk;
      req_data_i[0] = Junk; req_data_i[1] = Junk;
      #1;
      chk({tag, "/issue_valid"}, rms_in_valid_o, 1'b1);
      chk({tag, "/issue_a"}, rms_a_o, opnd);
      chk({tag, "/issue_rdy"}, req_ready_o, 2'b00);
      chk({tag, "/issue_rsp"}, rsp_valid_o, 2'b00);
    end
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      rms_in_ready_i = 1'b0;
      rms_out_valid_i = (c == lat - 1);
      rms_result_i = ~rms_a_o;
      #1;
      chk({tag, "/busy_in"}, rms_in_valid_o, 1'b0);
      chk({tag, "/busy_a"}, rms_a_o, opnd);
      chk({tag, "/busy_rsp"}, rsp_valid_o, 2'b00);
    end
    for (int b = 0; b <= bp; b++) begin
      @(negedge clk);
      rms_out_valid_i = 1'b0; rms_result_i = '0;
      req_valid_i = 2'b11;
      rsp_ready_i = (b == bp) ? exp_grant : ~exp_grant;
      #1;
      chk({tag, "/rsp_valid"}, rsp_valid_o, exp_grant);
      chk({tag, "/rsp_data"}, rsp_data_o, res);
      chk({tag, "/rsp_rdy"}, req_ready_o, 2'b00);
    end
  endtask

  initial begin
    int base;
    rst_ni = 1'b0; req_valid_i = '0; rsp_ready_i = '0; req_data_i = '0;
    rms_in_ready_i = 1'b0; rms_out_valid_i = 1'b0; rms_result_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst/rdy", req_ready_o, 2'b00);
    chk("rst/rsp", rsp_valid_o, 2'b00);
    chk("rst/in", rms_in_valid_o, 1'b0);
    chk("rst/a", rms_a_o, '0);
    chk("rst/data", rsp_data_o, '0);
    rst_ni = 1'b1;

    txn("cont0", 2'b11, 2'b01, 0, 3, 0, 1'b0);
    txn("cont1", 2'b11, 2'b10, 0, 3, 0, 1'b0);
    txn("cont2", 2'b11, 2'b01, 0, 3, 0, 1'b0);
    txn("cont3", 2'b11, 2'b10, 0, 3, 0, 1'b0);

    base = rdy0_cnt;
    txn("single", 2'b01, 2'b01, 0, 10, 0, 1'b0);
    chk("single/rdy0_pulses", 32'(rdy0_cnt - base), 32'd1);

    txn("stall", 2'b11, 2'b10, 5, 4, 0, 1'b0);
    txn("bp", 2'b10, 2'b10, 0, 2, 4, 1'b0);
    txn("spur", 2'b01, 2'b01, 2, 3, 0, 1'b1);

    // Pointer is now 1: abort a transaction from requester 1 by reset.
    @(negedge clk);
    req_valid_i = 2'b11; req_data_i[0] = D0; req_data_i[1] = D1;
    rsp_ready_i = 2'b00; rms_in_ready_i = 1'b0;
    #1;
    chk("rstbusy/grant", req_ready_o, 2'b10);
    @(negedge clk);
    rms_in_ready_i = 1'b1;
    #1;
    chk("rstbusy/issue", rms_in_valid_o, 1'b1);
    @(negedge clk);
    rms_in_ready_i = 1'b0;
    #1;
    chk("rstbusy/busy", rms_in_valid_o, 1'b0);
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1; req_valid_i = 2'b00; rsp_ready_i = 2'b11;
    #1;
    chk("rstbusy/in", rms_in_valid_o, 1'b0);
    chk("rstbusy/a", rms_a_o, '0);
    chk("rstbusy/data", rsp_data_o, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rstbusy/no_rsp", rsp_valid_o, 2'b00);
    end
    txn("post_rst", 2'b11, 2'b01, 0, 2, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
